// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b1110;
  localparam logic [3:0] OP_BNE  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps,
// low WIDTH bits of the unsigned product.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0] mplier_p0;
  logic [WIDTH-1:0] addend;
  logic             running;

  // Counter parks at WIDTH when idle; stepping stops there on its own.
  assign running = (cnt_p0 != CNT_W'(WIDTH));
  assign addend  = mplier_p0[0] ? mcand_p0 : '0;
  // Product includes the current step, so it is final in the cycle last is high.
  assign product = acc_p0 + addend;
  assign last    = (cnt_p0 == CNT_W'(WIDTH - 1));

  // Step counter: cleared on load, advances once per step, parked by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= CNT_W'(WIDTH);
    end else if (load) begin
      cnt_p0 <= '0;
    end else if (running) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // Accumulator, shifted multiplicand and shifted multiplier.
  always_ff @(posedge clk) begin
    if (load) begin
      acc_p0    <= '0;
      mcand_p0  <= a;
      mplier_p0 <= b;
    end else if (running) begin
      acc_p0    <= product;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle execute-stage ALU: single-cycle ops complete via EXEC, MUL via
// the iterative multiplier; registered result/flags with a one-cycle done.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 12,
  parameter int MUL_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic                 use_imm,
  input  logic [3:0]           op,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 overflow,
  output logic                 branch_taken
);

  localparam int SH_W    = $clog2(WIDTH);
  localparam bit HAS_MUL = (MUL_EN != 0);

  function automatic logic [WIDTH-1:0] sext_imm(input logic [IMM_WIDTH-1:0] v);
    return {{(WIDTH - IMM_WIDTH){v[IMM_WIDTH-1]}}, v};
  endfunction

  state_t            state;
  logic [WIDTH-1:0]  b_sel;
  logic              accept;
  logic              start_mul;

  logic [WIDTH-1:0]  a_p0;
  logic [WIDTH-1:0]  b_p0;
  logic [3:0]        op_p0;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]  sum;
  logic [WIDTH-1:0]  diff;
  logic [SH_W-1:0]   shamt;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_ov;
  logic              alu_br;

  logic [WIDTH-1:0]  mul_product;
  logic              mul_last;

  assign b_sel     = use_imm ? sext_imm(imm) : op_b;
  assign accept    = (state == ST_IDLE) && start;
  assign start_mul = HAS_MUL && (op == OP_MUL);

  // ---- accept stage: operand capture ----
  // Latch operands, effective B and opcode on accept only.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= op_a;
      b_p0  <= b_sel;
      op_p0 <= op;
    end
  end

  // ---- execute stage: single-cycle datapath on latched operands ----
  assign a_s   = a_p0;
  assign b_s   = b_p0;
  assign sum   = a_p0 + b_p0;
  assign diff  = a_p0 - b_p0;
  assign shamt = b_p0[SH_W-1:0];

  // Result, overflow and branch decision for the latched opcode.
  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    alu_br  = 1'b0;
    case (op_p0)
      OP_AND:  alu_res = a_p0 & b_p0;
      OP_OR:   alu_res = a_p0 | b_p0;
      OP_XOR:  alu_res = a_p0 ^ b_p0;
      OP_ADD: begin
        alu_res = sum;
        alu_ov  = (a_p0[WIDTH-1] == b_p0[WIDTH-1]) && (sum[WIDTH-1] != a_p0[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ov  = (a_p0[WIDTH-1] != b_p0[WIDTH-1]) && (diff[WIDTH-1] != a_p0[WIDTH-1]);
      end
      OP_SRA:  alu_res = a_s >>> shamt;
      OP_SLL:  alu_res = a_p0 << shamt;
      OP_SRL:  alu_res = a_p0 >> shamt;
      OP_SLT:  alu_res = {{(WIDTH - 1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_res = {{(WIDTH - 1){1'b0}}, (a_p0 < b_p0)};
      OP_BEQ: begin
        alu_res = diff;
        alu_br  = (a_p0 == b_p0);
      end
      OP_BNE: begin
        alu_res = diff;
        alu_br  = (a_p0 != b_p0);
      end
      default: alu_res = '0;
    endcase
  end

  // ---- multiply stage: iterative multiplier, loaded on accept ----
  generate
    if (HAS_MUL) begin : g_mul
      alu_mul_iter #(
        .WIDTH(WIDTH)
      ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept && start_mul),
        .a       (op_a),
        .b       (b_sel),
        .product (mul_product),
        .last    (mul_last)
      );
    end else begin : g_no_mul
      assign mul_product = '0;
      assign mul_last    = 1'b0;
    end
  endgenerate

  // ---- output stage: control FSM with registered result and flags ----
  // FSM: IDLE accepts, EXEC/MUL register outputs and raise done, DONE returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= start_mul ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          result       <= alu_res;
          zero         <= (alu_res == '0);
          overflow     <= alu_ov;
          branch_taken <= alu_br;
          done         <= 1'b1;
          state        <= ST_DONE;
        end
        ST_MUL: begin
          if (mul_last) begin
            result       <= mul_product;
            zero         <= (mul_product == '0);
            overflow     <= 1'b0;
            branch_taken <= 1'b0;
            done         <= 1'b1;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed testbench for alu_multiciclo (WIDTH=32, IMM_WIDTH=12, MUL_EN=1).
module tb_alu_multiciclo;

  localparam logic [3:0] T_AND  = 4'b0000;
  localparam logic [3:0] T_OR   = 4'b0001;
  localparam logic [3:0] T_ADD  = 4'b0010;
  localparam logic [3:0] T_UNK  = 4'b0011;
  localparam logic [3:0] T_XOR  = 4'b0100;
  localparam logic [3:0] T_SRA  = 4'b0101;
  localparam logic [3:0] T_SUB  = 4'b0110;
  localparam logic [3:0] T_SLL  = 4'b0111;
  localparam logic [3:0] T_SRL  = 4'b1000;
  localparam logic [3:0] T_SLT  = 4'b1001;
  localparam logic [3:0] T_SLTU = 4'b1010;
  localparam logic [3:0] T_MUL  = 4'b1011;
  localparam logic [3:0] T_BEQ  = 4'b1110;
  localparam logic [3:0] T_BNE  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [11:0] imm;
  logic        use_imm;
  logic [3:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        branch_taken;

  int checks = 0;
  int errors = 0;

  alu_multiciclo #(
    .WIDTH(32),
    .IMM_WIDTH(12),
    .MUL_EN(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op_a         (op_a),
    .op_b         (op_b),
    .imm          (imm),
    .use_imm      (use_imm),
    .op           (op),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .zero         (zero),
    .overflow     (overflow),
    .branch_taken (branch_taken)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: drive, accept, scramble inputs, wait for done, check.
  task automatic exec_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic ui, input logic [11:0] im,
                         input logic [31:0] er, input logic eo, input logic eb,
                         input int elat);
    int lat;
    @(negedge clk);
    op = o; op_a = a; op_b = b; use_imm = ui; imm = im; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; imm = 12'h5A5; op = T_UNK;
    lat = 1;
    check({tag, " busy_after_accept"}, {31'b0, busy}, 32'd1);
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " result"}, result, er);
    check({tag, " zero"}, {31'b0, zero}, {31'b0, (er == 32'd0)});
    check({tag, " overflow"}, {31'b0, overflow}, {31'b0, eo});
    check({tag, " branch"}, {31'b0, branch_taken}, {31'b0, eb});
    check({tag, " busy_at_done"}, {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, {31'b0, done}, 32'd0);
    check({tag, " idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int dcount;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; imm = '0; use_imm = 1'b0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", {31'b0, zero}, 32'd0);
    check("reset overflow", {31'b0, overflow}, 32'd0);
    check("reset branch", {31'b0, branch_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic and overflow boundaries
    exec_op("add_ovf",  T_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 12'h000, 32'h8000_0000, 1'b1, 1'b0, 2);
    exec_op("add_wrap", T_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 1'b0, 2);
    exec_op("sub_imm",  T_SUB, 32'd10, 32'd77, 1'b1, 12'hFFF, 32'd11, 1'b0, 1'b0, 2);
    exec_op("sub_ovf",  T_SUB, 32'h8000_0000, 32'd1, 1'b0, 12'h000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);

    // Branches
    exec_op("beq_eq", T_BEQ, 32'd5, 32'd5, 1'b0, 12'h000, 32'd0, 1'b0, 1'b1, 2);
    exec_op("bne_eq", T_BNE, 32'd5, 32'd5, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 2);
    exec_op("bne_ne", T_BNE, 32'd9, 32'd4, 1'b0, 12'h000, 32'd5, 1'b0, 1'b1, 2);
    exec_op("beq_ne", T_BEQ, 32'd9, 32'd4, 1'b0, 12'h000, 32'd5, 1'b0, 1'b0, 2);

    // Shifts and compares
    exec_op("sra",      T_SRA,  32'h8000_0000, 32'd4,  1'b0, 12'h000, 32'hF800_0000, 1'b0, 1'b0, 2);
    exec_op("srl",      T_SRL,  32'h8000_0000, 32'd4,  1'b0, 12'h000, 32'h0800_0000, 1'b0, 1'b0, 2);
    exec_op("srl_mask", T_SRL,  32'h8000_0000, 32'h24, 1'b0, 12'h000, 32'h0800_0000, 1'b0, 1'b0, 2);
    exec_op("sll_imm",  T_SLL,  32'd1, 32'd0, 1'b1, 12'h01F, 32'h8000_0000, 1'b0, 1'b0, 2);
    exec_op("slt",      T_SLT,  32'hFFFF_FFFF, 32'd1, 1'b0, 12'h000, 32'd1, 1'b0, 1'b0, 2);
    exec_op("sltu",     T_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 2);

    // Logic ops, including a negative sign-extended immediate
    exec_op("and",     T_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 12'h000, 32'hF000_F000, 1'b0, 1'b0, 2);
    exec_op("or",      T_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 12'h000, 32'hFFF0_FFF0, 1'b0, 1'b0, 2);
    exec_op("xor",     T_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 12'h000, 32'h0FF0_0FF0, 1'b0, 1'b0, 2);
    exec_op("and_imm", T_AND, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 12'h800, 32'h1234_5000, 1'b0, 1'b0, 2);

    // MUL with start pulses (different op/operands) during busy
    @(negedge clk);
    op = T_MUL; op_a = 32'h0001_0001; op_b = 32'h0001_0001; use_imm = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    op = T_ADD; op_a = 32'd1; op_b = 32'd1;
    repeat (10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("mul latency", lat, 33);
    check("mul result", result, 32'h0002_0001);
    check("mul zero", {31'b0, zero}, 32'd0);
    check("mul busy_at_done", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("mul done_one_cycle", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    check("mul no_queued_start", {31'b0, busy}, 32'd0);

    // Reset 10 cycles into a MUL
    @(negedge clk);
    op = T_MUL; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mulrst busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mulrst busy", {31'b0, busy}, 32'd0);
    check("mulrst done", {31'b0, done}, 32'd0);
    check("mulrst result", result, 32'd0);
    check("mulrst zero", {31'b0, zero}, 32'd0);
    dcount = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcount++;
    end
    check("mulrst no_done", dcount, 0);
    check("mulrst idle", {31'b0, busy}, 32'd0);
    exec_op("add_after_rst", T_ADD, 32'd3, 32'd4, 1'b0, 12'h000, 32'd7, 1'b0, 1'b0, 2);

    // Unknown opcode after a nonzero result
    exec_op("unknown", T_UNK, 32'd5, 32'd6, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 2);

    // Back-to-back with start held: accepts on edges 0,3,6; done on 1,4,7
    @(negedge clk);
    op = T_ADD; op_a = 32'd0; op_b = 32'd100; use_imm = 1'b0; start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b done_k%0d", k), {31'b0, done}, ((k % 3) == 1) ? 32'd1 : 32'd0);
      if (done === 1'b1)
        check($sformatf("b2b result_k%0d", k), result, 32'(k - 1 + 100));
      op_a = 32'(k + 1);
    end
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
Parametrised multi-cycle ALU for the datapath's execute stage. It takes operands and an opcode on a start strobe and returns a registered result, flags and a branch decision, with a one-cycle done pulse. Single-cycle ops finish in 1 cycle. MUL runs an iterative shift-add over WIDTH cycles. The FSM holds a busy signal so the control state machine stalls execute until done.

Parameters:
WIDTH, 32, datapath width in bits (power of 2, >= 8)
IMM_WIDTH, 12, immediate width; sign-extended to WIDTH
MUL_EN, 1, 1 = MUL op implemented; 0 = MUL treated as unknown op

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request strobe; sampled only in IDLE
op_a  input  WIDTH  operand A (register read 1)
op_b  input  WIDTH  operand B (register read 2)
imm  input  IMM_WIDTH  two's-complement immediate
use_imm  input  1  1 = operand B is sign-extended imm
op  input  4  operation code, see Behaviour
busy  output  1  high while operation in progress (not IDLE)
done  output  1  one-cycle pulse, result/flags valid from this cycle
result  output  WIDTH  registered result, held until next done
zero  output  1  result == 0, registered with result
overflow  output  1  signed overflow for ADD/SUB, else 0
branch_taken  output  1  branch decision for BEQ/BNE, else 0

Behaviour:
- Reset (rst_n low, async): state IDLE, busy=0, done=0, result=0, zero=0, overflow=0, branch_taken=0. Reset mid-MUL aborts with no done pulse.
- B = use_imm ? sign_extend(imm) : op_b. Sign extension replaces any separate sign flag.
- Ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 XOR.
- Shift ops: 0101 SRA (arithmetic), 0111 SLL, 1000 SRL. Shift amount = B[log2(WIDTH)-1:0].
- Compare ops: 1001 SLT (signed, result 1/0), 1010 SLTU (unsigned).
- 1011 MUL: low WIDTH bits of A*B, unsigned.
- Branch ops: 1110 BEQ, 1111 BNE. For these, result = A-B and branch_taken = (A==B) or (A!=B), computed from the operands in the accept cycle, never from the previous result.
- Unknown op: result=0, flags 0, done still pulses (one-cycle).
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE: start=1 with a single-cycle op -> EXEC. start=1 with MUL and MUL_EN=1 -> MUL. Operands, op and B are latched on accept.
  - EXEC: compute, register outputs -> DONE.
  - MUL: one shift-add step per cycle, WIDTH steps, step counter width log2(WIDTH)+1. After the last step -> DONE.
  - DONE: done=1 for exactly this cycle -> IDLE.
- busy=1 in EXEC, MUL and DONE.
- Latency from the accept edge to done high: single-cycle ops 2 edges; MUL WIDTH+1 edges.
- start while busy is ignored: not queued, no effect on the latched operands. start on the same edge DONE->IDLE is ignored; it is accepted on the following cycle.
- Inputs may change after accept; only the latched copies are used.
- overflow: ADD sets it when the operand signs match and the result sign differs. SUB sets it when the operand signs differ and the result sign differs from A.
- Wrap-around: ADD/SUB/MUL results are modulo 2^WIDTH.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SRA, OP_SLL, OP_SRL, OP_SLT, OP_SLTU, OP_MUL, OP_BEQ, OP_BNE.
  - state encoding: ST_IDLE, ST_EXEC, ST_MUL, ST_DONE.
- One sub-module, alu_mul_iter: the iterative shift-add multiplier.
  - Inputs: clk, rst_n, load, a, b.
  - Outputs: product, last.
  - Instantiated only when MUL_EN=1.

Test Plan:
- WIDTH=32, ADD A=0x7FFFFFFF, B=1 -> done 2 edges after accept, result=0x80000000, overflow=1, zero=0.
- SUB with use_imm=1, A=10, imm=0xFFF (-1) -> result=11. Then BEQ A=5, B=5 -> branch_taken=1, zero=1. BNE A=5, B=5 -> branch_taken=0.
- SRA A=0x80000000, B=4 -> 0xF8000000. SRL same operands -> 0x08000000. SLT A=-1, B=1 -> 1. SLTU same -> 0.
- MUL A=0x10001, B=0x10001 -> busy high for 33 edges, then result=0x00020001 and done for one cycle. start pulses during busy are ignored.
- Reset asserted 10 cycles into a MUL -> outputs 0 immediately, no done pulse. After release, a new ADD 3+4 gives 7.
- Unknown op 0011 -> result=0, done pulses. Back-to-back: start held high continuously -> one done every 3 cycles, each result from the operands latched at its accept.
